uart_cmd_asm: RTL and testbench

Byte-to-command assembler directly downstream of the UART receiver. Consumes received bytes via the receiver's `rdy`/`clr_rdy` handshake and packs three consecutive bytes (opcode, then payload MSB first, then payload LSB) into a 24-bit command word. Exposes the command word to the control logic with its own ready/clear handshake. Discards partial commands when the inter-byte gap exceeds a timeout.

---
 rtl/uart_cmd_asm.sv | 122 ++++++++++++
 tb/tb_uart_cmd_asm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_asm.sv
// Packs three UART bytes (opcode, data_hi, data_lo) into a 24-bit command word.
// Partial commands are dropped when the inter-byte gap reaches TIMEOUT cycles.
module uart_cmd_asm #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_rdy,
   output logic        clr_rx_rdy,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   output logic        timeout,
   output logic        overrun
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] GAP_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, GOT1, GOT2} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] gap_q, gap_d;
   logic [7:0]    op_q, op_d;
   logic [7:0]    hi_q, hi_d;
   logic [23:0]   cmd_q, cmd_d;
   logic          cmd_rdy_q, cmd_rdy_d;
   logic          clr_rx_q, clr_rx_d;
   logic          timeout_q, timeout_d;
   logic          overrun_q, overrun_d;
   logic          accept;

   // The receiver still shows rdy during our clear cycle, so that cycle is ignored.
   assign accept = rx_rdy & ~clr_rx_q;

   always_comb begin
      state_d   = state_q;
      gap_d     = '0;
      op_d      = op_q;
      hi_d      = hi_q;
      cmd_d     = cmd_q;
      cmd_rdy_d = cmd_rdy_q;
      overrun_d = overrun_q;
      clr_rx_d  = accept;
      timeout_d = 1'b0;

      if (clr_cmd_rdy) begin
         cmd_rdy_d = 1'b0;
         overrun_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = rx_data;
               state_d = GOT1;
            end
         end
         GOT1: begin
            if (accept) begin
               hi_d    = rx_data;
               state_d = GOT2;
            end else if (gap_q == GAP_MAX) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               op_d      = '0;
            end else begin
               gap_d = gap_q + CW'(1);
            end
         end
         GOT2: begin
            if (accept) begin
               // A new word beats a same-cycle acknowledge.
               cmd_d     = {op_q, hi_q, rx_data};
               cmd_rdy_d = 1'b1;
               if (cmd_rdy_q && !clr_cmd_rdy) overrun_d = 1'b1;
               state_d   = IDLE;
            end else if (gap_q == GAP_MAX) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               op_d      = '0;
               hi_d      = '0;
            end else begin
               gap_d = gap_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gap_q     <= '0;
         op_q      <= '0;
         hi_q      <= '0;
         cmd_q     <= '0;
         cmd_rdy_q <= 1'b0;
         clr_rx_q  <= 1'b0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         op_q      <= op_d;
         hi_q      <= hi_d;
         cmd_q     <= cmd_d;
         cmd_rdy_q <= cmd_rdy_d;
         clr_rx_q  <= clr_rx_d;
         timeout_q <= timeout_d;
         overrun_q <= overrun_d;
      end
   end

   assign clr_rx_rdy = clr_rx_q;
   assign cmd        = cmd_q;
   assign cmd_rdy    = cmd_rdy_q;
   assign timeout    = timeout_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_asm.sv
// Directed bench for uart_cmd_asm: vector table of full commands plus corner sequences.
module tb_uart_cmd_asm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_rdy = 1'b0;
   logic        clr_cmd_rdy = 1'b0;
   logic        sel = 1'b0;

   logic        rx_rdy_a, rx_rdy_b;
   logic        clr_rx_a, clr_rx_b, cmd_rdy_a, cmd_rdy_b;
   logic        to_a, to_b, ovr_a, ovr_b;
   logic [23:0] cmd_a, cmd_b;
   logic        clr_rx_s, cmd_rdy_s, to_s, ovr_s;
   logic [23:0] cmd_s;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int clr_cnt = 0, clr_dbl = 0, to_cnt = 0, to_cyc = 0, last_acc = 0;
   logic clr_prev = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rx_rdy_a  = rx_rdy & ~sel;
   assign rx_rdy_b  = rx_rdy & sel;
   assign clr_rx_s  = sel ? clr_rx_b  : clr_rx_a;
   assign cmd_rdy_s = sel ? cmd_rdy_b : cmd_rdy_a;
   assign to_s      = sel ? to_b      : to_a;
   assign ovr_s     = sel ? ovr_b     : ovr_a;
   assign cmd_s     = sel ? cmd_b     : cmd_a;

   uart_cmd_asm dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy_a),
      .clr_rx_rdy(clr_rx_a), .cmd(cmd_a), .cmd_rdy(cmd_rdy_a),
      .clr_cmd_rdy(clr_cmd_rdy), .timeout(to_a), .overrun(ovr_a)
   );

   uart_cmd_asm #(.TIMEOUT(64)) dut_t (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy_b),
      .clr_rx_rdy(clr_rx_b), .cmd(cmd_b), .cmd_rdy(cmd_rdy_b),
      .clr_cmd_rdy(clr_cmd_rdy), .timeout(to_b), .overrun(ovr_b)
   );

   // Pulse monitor on the selected instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (clr_rx_s) begin
         clr_cnt = clr_cnt + 1;
         if (clr_prev) clr_dbl = clr_dbl + 1;
      end
      clr_prev = clr_rx_s;
      if (to_s) begin
         to_cnt = to_cnt + 1;
         to_cyc = cyc;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Receiver model: rdy sampled at the accept edge and the ignored clear edge.
   task automatic send_byte(input logic [7:0] b, input bit clr3);
      @(negedge clk);
      rx_data = b;
      rx_rdy  = 1'b1;
      if (clr3) clr_cmd_rdy = 1'b1;
      @(posedge clk);
      #1;
      last_acc    = cyc;
      clr_cmd_rdy = 1'b0;
      @(posedge clk);
      #1 rx_rdy = 1'b0;
   endtask

   task automatic ack();
      @(negedge clk);
      clr_cmd_rdy = 1'b1;
      @(posedge clk);
      #1 clr_cmd_rdy = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      logic [7:0]  b0, b1, b2;
      int          gap;
      bit          clr3;
      bit          do_ack;
      logic [23:0] ecmd;
      bit          erdy, eovr;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int c0, t0, acc2;
      logic [23:0] keep;

      tbl[0] = '{8'hA5, 8'h12, 8'h34, 320, 1'b0, 1'b1, 24'hA51234, 1'b1, 1'b0};
      tbl[1] = '{8'h11, 8'h11, 8'h11, 0,   1'b0, 1'b0, 24'h111111, 1'b1, 1'b0};
      tbl[2] = '{8'h22, 8'h22, 8'h22, 0,   1'b0, 1'b1, 24'h222222, 1'b1, 1'b1};
      tbl[3] = '{8'h01, 8'h02, 8'h03, 5,   1'b0, 1'b0, 24'h010203, 1'b1, 1'b0};
      tbl[4] = '{8'h04, 8'h05, 8'h06, 3,   1'b1, 1'b0, 24'h040506, 1'b1, 1'b0};
      tbl[5] = '{8'h00, 8'hFF, 8'h80, 10,  1'b0, 1'b0, 24'h00FF80, 1'b1, 1'b1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd", {8'h0, cmd_s}, 32'h0);
      chk("rst_cmd_rdy", {31'h0, cmd_rdy_s}, 32'h0);
      chk("rst_clr_rx", {31'h0, clr_rx_s}, 32'h0);
      chk("rst_timeout", {31'h0, to_s}, 32'h0);
      chk("rst_overrun", {31'h0, ovr_s}, 32'h0);

      // Receiver clears late: rdy is high through a whole cycle before the accept
      // and stays up through the entire clear cycle.
      c0 = clr_cnt;
      @(posedge clk);
      #1;
      rx_data = 8'h5A;
      rx_rdy  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rx_rdy = 1'b0;
      chk("late_clr_pulses", clr_cnt - c0, 1);
      send_byte(8'h6B, 1'b0);
      send_byte(8'h7C, 1'b0);
      chk("late_cmd", {8'h0, cmd_s}, 32'h005A6B7C);
      ack();

      for (int i = 0; i < 6; i++) begin
         c0 = clr_cnt;
         t0 = to_cnt;
         send_byte(tbl[i].b0, 1'b0);
         repeat (tbl[i].gap) @(posedge clk);
         send_byte(tbl[i].b1, 1'b0);
         repeat (tbl[i].gap) @(posedge clk);
         send_byte(tbl[i].b2, tbl[i].clr3);
         @(negedge clk);
         chk($sformatf("v%0d_cmd", i), {8'h0, cmd_s}, {8'h0, tbl[i].ecmd});
         chk($sformatf("v%0d_cmd_rdy", i), {31'h0, cmd_rdy_s}, {31'h0, tbl[i].erdy});
         chk($sformatf("v%0d_overrun", i), {31'h0, ovr_s}, {31'h0, tbl[i].eovr});
         chk($sformatf("v%0d_clr_pulses", i), clr_cnt - c0, 3);
         chk($sformatf("v%0d_no_timeout", i), to_cnt - t0, 0);
         if (tbl[i].do_ack) begin
            ack();
            chk($sformatf("v%0d_ack_rdy", i), {31'h0, cmd_rdy_s}, 32'h0);
            chk($sformatf("v%0d_ack_ovr", i), {31'h0, ovr_s}, 32'h0);
            chk($sformatf("v%0d_ack_cmd", i), {8'h0, cmd_s}, {8'h0, tbl[i].ecmd});
         end
      end
      chk("clr_single_cycle", clr_dbl, 0);

      // Reset while waiting for the third byte, with a pending overrun word.
      send_byte(8'h77, 1'b0);
      send_byte(8'h88, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("grst_cmd", {8'h0, cmd_s}, 32'h0);
      chk("grst_cmd_rdy", {31'h0, cmd_rdy_s}, 32'h0);
      chk("grst_overrun", {31'h0, ovr_s}, 32'h0);
      chk("grst_clr_rx", {31'h0, clr_rx_s}, 32'h0);
      send_byte(8'h99, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      @(negedge clk);
      chk("grst_after_cmd", {8'h0, cmd_s}, 32'h0099AABB);
      chk("grst_after_rdy", {31'h0, cmd_rdy_s}, 32'h1);

      // Timeout on the TIMEOUT=64 instance.
      sel = 1'b1;
      @(negedge clk);
      t0 = to_cnt;
      keep = cmd_s;
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      acc2 = last_acc;
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("to_pulses", to_cnt - t0, 1);
      chk("to_latency", to_cyc - acc2, 64);
      chk("to_cmd_kept", {8'h0, cmd_s}, {8'h0, keep});
      chk("to_cmd_rdy", {31'h0, cmd_rdy_s}, 32'h0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b0);
      send_byte(8'h05, 1'b0);
      @(negedge clk);
      chk("to_after_cmd", {8'h0, cmd_s}, 32'h00030405);
      chk("to_after_rdy", {31'h0, cmd_rdy_s}, 32'h1);
      chk("to_after_pulses", to_cnt - t0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
